hazard_controller: RTL and testbench
====================================

# hazard_controller

Pipeline sequencing controller for the 4-stage CPU (IF, ID, EX, MEM/WB). It takes hazard inputs from the decode, execute and memory stages, then drives the per-stage enables, the flush strobes and the PC source select. It handles three cases: load-use stalls, taken-branch flushes and memory-wait freezes. It sits beside the pipeline registers and is the only block that may stall or flush them.

## Interface
- `REG_AW`, 3: register-address width.
- `LOAD_BUBBLES`, 1: bubbles inserted per load-use hazard, range 1–7.
- `CNT_W`, 16: width of the performance counters.

- `clk`  in  1  rising-edge clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `i_id_valid`  in  1  ID stage holds a real instruction.
- `i_id_rs1`, `i_id_rs2`  in  `REG_AW`  ID source registers.
- `i_id_uses_rs2`  in  1  ID reads `rs2`; this is the inverse of the decoder's immediate flag.
- `i_ex_regwrite`, `i_ex_memtoreg`  in  1  EX-stage control bits.
- `i_ex_rd`  in  `REG_AW`  EX destination register.
- `i_ex_branch`  in  1  EX holds a branch.
- `i_ex_taken`  in  1  branch condition is true (src1 − imm == 0).
- `i_mem_req`  in  1  MEM stage is issuing a load or store.
- `i_mem_ready`  in  1  memory completes the access this cycle.
- `o_pc_en`, `o_ifid_en`, `o_idex_en`, `o_exmem_en`  out  1  stage register enables.
- `o_ifid_flush`, `o_idex_flush`  out  1  synchronous bubble insert.
- `o_pc_sel`  out  1  1 selects the branch target.
- `o_state`  out  2  current FSM state.
- `o_stall_cnt`, `o_flush_cnt`  out  `CNT_W`  performance counters.

## Operation
Combinational terms:
- `load_use` = `i_id_valid` & `i_ex_regwrite` & `i_ex_memtoreg` & (`i_ex_rd`==`i_id_rs1` | (`i_id_uses_rs2` & `i_ex_rd`==`i_id_rs2`)).
- `taken` = `i_ex_branch` & `i_ex_taken`.
- `mem_stall` = `i_mem_req` & !`i_mem_ready`.

Default outputs: all enables 1, flushes 0, `o_pc_sel` 0.

FSM states: RUN=00, LOAD_STALL=01, BR_FLUSH=10, MEM_WAIT=11. Priority: `mem_stall` > `taken` > `load_use`.

RUN:
- `mem_stall`: all four enables 0, no flush. Next state MEM_WAIT.
- `taken`: `o_pc_sel`=1, `o_ifid_flush`=1, `o_idex_flush`=1. Next state BR_FLUSH.
- `load_use`: `o_pc_en`=0, `o_ifid_en`=0, `o_idex_flush`=1. Next state LOAD_STALL with `bub_cnt`=`LOAD_BUBBLES`−1. If `LOAD_BUBBLES`==1, stay in RUN.

LOAD_STALL:
- Same outputs as the `load_use` cycle. `bub_cnt` decrements each cycle.
- Return to RUN in the cycle `bub_cnt` reaches 0.
- `mem_stall` overrides: freeze and go to MEM_WAIT; the remaining bubble count is held.

BR_FLUSH:
- One cycle with `o_ifid_flush`=1, covering instruction-memory latency on the target fetch. Next state RUN.
- `mem_stall` overrides: freeze, set `br_pend`, go to MEM_WAIT.

MEM_WAIT:
- While `i_mem_ready`=0: all enables 0, flushes 0.
- When `i_mem_ready`=1: release the pipeline.
  - `br_pend` set: emit the BR_FLUSH cycle outputs, clear `br_pend`, go to RUN.
  - `bub_cnt`≠0: return to LOAD_STALL.
  - Otherwise: evaluate exactly as RUN with `mem_stall`=0.

## Timing
- Zero-cycle decision: outputs depend on the current state and current-cycle inputs. State, `bub_cnt` and `br_pend` update on the rising edge of `clk`.
- Load-use penalty is `LOAD_BUBBLES` cycles. Taken-branch penalty is 2 cycles. Memory wait lasts as long as `i_mem_ready` is low, with no timeout.
- While `reset_n`=0:
  - all enables 0, both flushes 1, `o_pc_sel` 0;
  - state RUN, `bub_cnt` 0, `br_pend` 0, counters 0.
- Reset asserted mid-stall or mid-flush abandons the sequence immediately.
- The first cycle after reset release evaluates as RUN.
- `load_use` together with `taken` in the same cycle: `taken` wins, and the flushed ID instruction's hazard is dropped.

## Configuration
- `HAZARD_PERF_CNT_EN` defined:
  - `o_stall_cnt` increments every cycle with `o_pc_en`=0, outside reset.
  - `o_flush_cnt` increments on each cycle with `o_pc_sel`=1.
  - Both counters saturate at 2^`CNT_W`−1.
- Not defined: both outputs are constant 0 and no counter flops exist.

## Test plan
- EX load to r3, ID reads r3 via `rs2` with `i_id_uses_rs2`=1, `LOAD_BUBBLES`=2 → 2 cycles of `o_pc_en`=0 and `o_idex_flush`=1, states RUN→LOAD_STALL→RUN. With `i_id_uses_rs2`=0 → no stall.
- `i_ex_branch`=1, `i_ex_taken`=1 → cycle 0: `o_pc_sel`=1 with both flushes 1; cycle 1: only `o_ifid_flush`=1; cycle 2: defaults. `o_flush_cnt`=1.
- `i_mem_req`=1 with `i_mem_ready` low for 3 cycles → 3 frozen cycles, release on the ready cycle. `o_stall_cnt`=3.
- `mem_stall` in the BR_FLUSH cycle, ready after 2 cycles → 2 freeze cycles, then one `o_ifid_flush` cycle, then RUN.
- `reset_n` pulled low during LOAD_STALL → outputs go to reset values immediately, counters clear, `o_state`=00.
- `load_use` and `taken` in the same cycle → branch-flush outputs only, no LOAD_STALL entry.

Source files
------------

// File: rtl/hazard_controller.sv
// Pipeline hazard sequencer: load-use stalls, taken-branch flushes, memory-wait freezes.
// Latency: zero-cycle decisions from current state and inputs; state updates on clk rising edge.
// Backpressure: a memory wait freezes all stage enables until i_mem_ready. Optional HAZARD_PERF_CNT_EN adds perf counters.
module hazard_controller #(
    parameter int REG_AW       = 3,
    parameter int LOAD_BUBBLES = 1,
    parameter int CNT_W        = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              i_id_valid,
    input  logic [REG_AW-1:0] i_id_rs1,
    input  logic [REG_AW-1:0] i_id_rs2,
    input  logic              i_id_uses_rs2,
    input  logic              i_ex_regwrite,
    input  logic              i_ex_memtoreg,
    input  logic [REG_AW-1:0] i_ex_rd,
    input  logic              i_ex_branch,
    input  logic              i_ex_taken,
    input  logic              i_mem_req,
    input  logic              i_mem_ready,
    output logic              o_pc_en,
    output logic              o_ifid_en,
    output logic              o_idex_en,
    output logic              o_exmem_en,
    output logic              o_ifid_flush,
    output logic              o_idex_flush,
    output logic              o_pc_sel,
    output logic [1:0]        o_state,
    output logic [CNT_W-1:0]  o_stall_cnt,
    output logic [CNT_W-1:0]  o_flush_cnt
);

    typedef enum logic [1:0] {
        RUN        = 2'b00,
        LOAD_STALL = 2'b01,
        BR_FLUSH   = 2'b10,
        MEM_WAIT   = 2'b11
    } state_t;

    state_t     state, state_nxt;
    logic [2:0] bub_cnt, bub_nxt;
    logic       br_pend, br_nxt;

    logic load_use, taken, mem_stall, eval_run;
    logic pc_en, ifid_en, idex_en, exmem_en, ifid_flush, idex_flush, pc_sel;

    assign load_use  = i_id_valid & i_ex_regwrite & i_ex_memtoreg &
                       ((i_ex_rd == i_id_rs1) | (i_id_uses_rs2 & (i_ex_rd == i_id_rs2)));
    assign taken     = i_ex_branch & i_ex_taken;
    assign mem_stall = i_mem_req & ~i_mem_ready;

    always_comb begin
        state_nxt  = state;
        bub_nxt    = bub_cnt;
        br_nxt     = br_pend;
        eval_run   = 1'b0;
        pc_en      = 1'b1;
        ifid_en    = 1'b1;
        idex_en    = 1'b1;
        exmem_en   = 1'b1;
        ifid_flush = 1'b0;
        idex_flush = 1'b0;
        pc_sel     = 1'b0;

        case (state)
            RUN: eval_run = 1'b1;
            LOAD_STALL: begin
                if (mem_stall) begin
                    {pc_en, ifid_en, idex_en, exmem_en} = 4'b0000;
                    state_nxt = MEM_WAIT;
                end else begin
                    pc_en      = 1'b0;
                    ifid_en    = 1'b0;
                    idex_flush = 1'b1;
                    bub_nxt    = bub_cnt - 3'd1;
                    if (bub_cnt <= 3'd1) state_nxt = RUN;
                end
            end
            BR_FLUSH: begin
                if (mem_stall) begin
                    {pc_en, ifid_en, idex_en, exmem_en} = 4'b0000;
                    br_nxt    = 1'b1;
                    state_nxt = MEM_WAIT;
                end else begin
                    ifid_flush = 1'b1;
                    state_nxt  = RUN;
                end
            end
            default: begin
                if (!i_mem_ready) begin
                    {pc_en, ifid_en, idex_en, exmem_en} = 4'b0000;
                end else if (br_pend) begin
                    // Deferred target-fetch flush from a branch caught by the memory wait
                    ifid_flush = 1'b1;
                    br_nxt     = 1'b0;
                    state_nxt  = RUN;
                end else if (bub_cnt != 3'd0) begin
                    state_nxt = LOAD_STALL;
                end else begin
                    eval_run = 1'b1;
                end
            end
        endcase

        // Common RUN decision; a memory stall only counts here when already in RUN
        if (eval_run) begin
            state_nxt = RUN;
            if (state == RUN && mem_stall) begin
                {pc_en, ifid_en, idex_en, exmem_en} = 4'b0000;
                state_nxt = MEM_WAIT;
            end else if (taken) begin
                pc_sel     = 1'b1;
                ifid_flush = 1'b1;
                idex_flush = 1'b1;
                state_nxt  = BR_FLUSH;
            end else if (load_use) begin
                pc_en      = 1'b0;
                ifid_en    = 1'b0;
                idex_flush = 1'b1;
                bub_nxt    = 3'(LOAD_BUBBLES - 1);
                state_nxt  = (LOAD_BUBBLES == 1) ? RUN : LOAD_STALL;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= RUN;
            bub_cnt <= 3'd0;
            br_pend <= 1'b0;
        end else begin
            state   <= state_nxt;
            bub_cnt <= bub_nxt;
            br_pend <= br_nxt;
        end
    end

    assign o_pc_en      = reset_n & pc_en;
    assign o_ifid_en    = reset_n & ifid_en;
    assign o_idex_en    = reset_n & idex_en;
    assign o_exmem_en   = reset_n & exmem_en;
    assign o_ifid_flush = ~reset_n | ifid_flush;
    assign o_idex_flush = ~reset_n | idex_flush;
    assign o_pc_sel     = reset_n & pc_sel;
    assign o_state      = state;

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt, flush_cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (!o_pc_en && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
            if (o_pc_sel && flush_cnt != '1) flush_cnt <= flush_cnt + 1'b1;
        end
    end

    assign o_stall_cnt = stall_cnt;
    assign o_flush_cnt = flush_cnt;
`else
    assign o_stall_cnt = '0;
    assign o_flush_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_controller.sv
// Directed bench for hazard_controller with LOAD_BUBBLES=2; outputs checked at the falling edge.
module tb_hazard_controller;

    localparam int REG_AW = 3;
    localparam int CNT_W  = 16;
`ifdef HAZARD_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              reset_n;
    logic              i_id_valid, i_id_uses_rs2;
    logic [REG_AW-1:0] i_id_rs1, i_id_rs2, i_ex_rd;
    logic              i_ex_regwrite, i_ex_memtoreg, i_ex_branch, i_ex_taken;
    logic              i_mem_req, i_mem_ready;
    logic              o_pc_en, o_ifid_en, o_idex_en, o_exmem_en;
    logic              o_ifid_flush, o_idex_flush, o_pc_sel;
    logic [1:0]        o_state;
    logic [CNT_W-1:0]  o_stall_cnt, o_flush_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    hazard_controller #(.REG_AW(REG_AW), .LOAD_BUBBLES(2), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset_n(reset_n),
        .i_id_valid(i_id_valid), .i_id_rs1(i_id_rs1), .i_id_rs2(i_id_rs2),
        .i_id_uses_rs2(i_id_uses_rs2), .i_ex_regwrite(i_ex_regwrite),
        .i_ex_memtoreg(i_ex_memtoreg), .i_ex_rd(i_ex_rd), .i_ex_branch(i_ex_branch),
        .i_ex_taken(i_ex_taken), .i_mem_req(i_mem_req), .i_mem_ready(i_mem_ready),
        .o_pc_en(o_pc_en), .o_ifid_en(o_ifid_en), .o_idex_en(o_idex_en),
        .o_exmem_en(o_exmem_en), .o_ifid_flush(o_ifid_flush), .o_idex_flush(o_idex_flush),
        .o_pc_sel(o_pc_sel), .o_state(o_state),
        .o_stall_cnt(o_stall_cnt), .o_flush_cnt(o_flush_cnt)
    );

    // {pc_en, ifid_en, idex_en, exmem_en, ifid_flush, idex_flush, pc_sel, state}
    logic [8:0] obs;
    assign obs = {o_pc_en, o_ifid_en, o_idex_en, o_exmem_en,
                  o_ifid_flush, o_idex_flush, o_pc_sel, o_state};

    function automatic logic [8:0] ex(input logic [3:0] en, input logic [1:0] fl,
                                      input logic sel, input logic [1:0] st);
        return {en, fl, sel, st};
    endfunction

    function automatic logic [31:0] cnt(input int n);
        return PERF ? 32'(n) : 32'd0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
        n_tests++;
        assert (got === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, expv);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs;
        i_id_valid = 0; i_id_uses_rs2 = 0; i_id_rs1 = '0; i_id_rs2 = '0; i_ex_rd = '0;
        i_ex_regwrite = 0; i_ex_memtoreg = 0; i_ex_branch = 0; i_ex_taken = 0;
        i_mem_req = 0; i_mem_ready = 0;
    endtask

    task automatic set_load_hazard(input logic uses_rs2);
        i_id_valid = 1; i_id_rs1 = 3'd1; i_id_rs2 = 3'd3; i_id_uses_rs2 = uses_rs2;
        i_ex_regwrite = 1; i_ex_memtoreg = 1; i_ex_rd = 3'd3;
    endtask

    initial begin
        reset_n = 0;
        clear_inputs();
        @(negedge clk);
        chk("reset_outs", 32'(obs), 32'(ex(4'b0000, 2'b11, 0, 2'b00)));
        chk("reset_stall_cnt", 32'(o_stall_cnt), 32'd0);
        tick(); reset_n = 1;
        @(negedge clk);
        chk("run_default", 32'(obs), 32'(ex(4'b1111, 2'b00, 0, 2'b00)));

        // Load-use through rs2, two bubbles
        tick(); set_load_hazard(1'b1);
        @(negedge clk);
        chk("lu_cycle0", 32'(obs), 32'(ex(4'b0011, 2'b01, 0, 2'b00)));
        tick();
        @(negedge clk);
        chk("lu_cycle1", 32'(obs), 32'(ex(4'b0011, 2'b01, 0, 2'b01)));
        tick(); clear_inputs();
        @(negedge clk);
        chk("lu_done", 32'(obs), 32'(ex(4'b1111, 2'b00, 0, 2'b00)));
        chk("lu_stall_cnt", 32'(o_stall_cnt), cnt(2));

        // Same registers but rs2 not read: no hazard
        tick(); set_load_hazard(1'b0);
        @(negedge clk);
        chk("no_rs2_use", 32'(obs), 32'(ex(4'b1111, 2'b00, 0, 2'b00)));
        tick();
        @(negedge clk);
        chk("no_rs2_state", 32'(o_state), 32'd0);

        // Taken branch
        tick(); clear_inputs(); i_ex_branch = 1; i_ex_taken = 1;
        @(negedge clk);
        chk("br_cycle0", 32'(obs), 32'(ex(4'b1111, 2'b11, 1, 2'b00)));
        tick(); clear_inputs();
        @(negedge clk);
        chk("br_cycle1", 32'(obs), 32'(ex(4'b1111, 2'b10, 0, 2'b10)));
        tick();
        @(negedge clk);
        chk("br_cycle2", 32'(obs), 32'(ex(4'b1111, 2'b00, 0, 2'b00)));
        chk("br_flush_cnt", 32'(o_flush_cnt), cnt(1));

        // Memory wait: three frozen cycles, release on ready
        tick(); i_mem_req = 1; i_mem_ready = 0;
        @(negedge clk);
        chk("mw_freeze0", 32'(obs), 32'(ex(4'b0000, 2'b00, 0, 2'b00)));
        tick();
        @(negedge clk);
        chk("mw_freeze1", 32'(obs), 32'(ex(4'b0000, 2'b00, 0, 2'b11)));
        tick();
        @(negedge clk);
        chk("mw_freeze2", 32'(obs), 32'(ex(4'b0000, 2'b00, 0, 2'b11)));
        tick(); i_mem_ready = 1;
        @(negedge clk);
        chk("mw_release", 32'(obs), 32'(ex(4'b1111, 2'b00, 0, 2'b11)));
        tick(); clear_inputs();
        @(negedge clk);
        chk("mw_back_run", 32'(obs), 32'(ex(4'b1111, 2'b00, 0, 2'b00)));
        chk("mw_stall_cnt", 32'(o_stall_cnt), cnt(5));

        // Memory stall hits the BR_FLUSH cycle
        tick(); i_ex_branch = 1; i_ex_taken = 1;
        @(negedge clk);
        chk("bm_taken", 32'(obs), 32'(ex(4'b1111, 2'b11, 1, 2'b00)));
        tick(); clear_inputs(); i_mem_req = 1; i_mem_ready = 0;
        @(negedge clk);
        chk("bm_freeze0", 32'(obs), 32'(ex(4'b0000, 2'b00, 0, 2'b10)));
        tick();
        @(negedge clk);
        chk("bm_freeze1", 32'(obs), 32'(ex(4'b0000, 2'b00, 0, 2'b11)));
        tick(); i_mem_ready = 1;
        @(negedge clk);
        chk("bm_pend_flush", 32'(obs), 32'(ex(4'b1111, 2'b10, 0, 2'b11)));
        tick(); clear_inputs();
        @(negedge clk);
        chk("bm_back_run", 32'(obs), 32'(ex(4'b1111, 2'b00, 0, 2'b00)));
        chk("bm_flush_cnt", 32'(o_flush_cnt), cnt(2));
        chk("bm_stall_cnt", 32'(o_stall_cnt), cnt(7));

        // Load-use and taken together: branch wins
        tick(); set_load_hazard(1'b1); i_ex_branch = 1; i_ex_taken = 1;
        @(negedge clk);
        chk("lt_cycle0", 32'(obs), 32'(ex(4'b1111, 2'b11, 1, 2'b00)));
        tick(); clear_inputs();
        @(negedge clk);
        chk("lt_cycle1", 32'(obs), 32'(ex(4'b1111, 2'b10, 0, 2'b10)));
        tick();
        @(negedge clk);
        chk("lt_cycle2", 32'(obs), 32'(ex(4'b1111, 2'b00, 0, 2'b00)));
        chk("lt_flush_cnt", 32'(o_flush_cnt), cnt(3));

        // Reset asserted during LOAD_STALL
        tick(); set_load_hazard(1'b1);
        tick();
        @(negedge clk);
        chk("rs_in_stall", 32'(o_state), 32'd1);
        #2 reset_n = 0;
        #1;
        chk("rs_outs", 32'(obs), 32'(ex(4'b0000, 2'b11, 0, 2'b00)));
        chk("rs_stall_cnt", 32'(o_stall_cnt), 32'd0);
        chk("rs_flush_cnt", 32'(o_flush_cnt), 32'd0);
        tick(); reset_n = 1; clear_inputs();
        @(negedge clk);
        chk("rs_after", 32'(obs), 32'(ex(4'b1111, 2'b00, 0, 2'b00)));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
